// File: rtl/partition_sweep_pkg.sv
// Shared definitions for the exhaustive partition checker.
//   - sweep_state_e : checker FSM states
//   - width helpers : accumulator widths chosen so no accumulator can overflow
//   - SWEEP_LEN     : number of patterns in a full sweep at the default width
package partition_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } sweep_state_e;

    localparam int DEF_NUM_IN  = 7;
    localparam int DEF_NUM_OUT = 4;
    localparam int SWEEP_LEN   = 2 ** DEF_NUM_IN;

    // Bits needed to hold a popcount of num_out bits (0..num_out).
    function automatic int pop_w(input int num_out);
        return $clog2(num_out + 1);
    endfunction

    // err_count can reach 2^num_in, so one extra bit.
    function automatic int err_w(input int num_in);
        return num_in + 1;
    endfunction

    // ham_sum can reach num_out * 2^num_in.
    function automatic int ham_w(input int num_in, input int num_out);
        return num_in + pop_w(num_out);
    endfunction

    // abs_err_sum can reach (2^num_out - 1) * 2^num_in.
    function automatic int abs_sum_w(input int num_in, input int num_out);
        return num_in + num_out;
    endfunction

endpackage

// File: rtl/sweep_err_metric.sv
// Combinational per-pattern error metrics for one exact/approx output pair.
//   exact, approx : partition outputs, treated as unsigned integers
//   mismatch      : 1 when the two differ
//   popcount      : number of differing bits
//   abs_err       : |exact - approx|
module sweep_err_metric
    import partition_sweep_pkg::*;
#(
    parameter int NUM_OUT = DEF_NUM_OUT,
    localparam int PW     = pop_w(NUM_OUT)
) (
    input  logic [NUM_OUT-1:0] exact,
    input  logic [NUM_OUT-1:0] approx,
    output logic               mismatch,
    output logic [PW-1:0]      popcount,
    output logic [NUM_OUT-1:0] abs_err
);

    function automatic logic [PW-1:0] count_ones(input logic [NUM_OUT-1:0] v);
        logic [PW-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < NUM_OUT; i++) begin
            cnt = cnt + PW'(v[i]);
        end
        return cnt;
    endfunction

    // Subtract the smaller from the larger so the result never wraps.
    function automatic logic [NUM_OUT-1:0] abs_diff(input logic [NUM_OUT-1:0] a,
                                                    input logic [NUM_OUT-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    always_comb begin
        mismatch = (exact != approx);
        popcount = count_ones(exact ^ approx);
        abs_err  = abs_diff(exact, approx);
    end

endmodule

// File: rtl/partition_exhaustive_checker.sv
// Exhaustive checker for one exact/approximate partition pair.
// Drives every pattern 0..2^NUM_IN-1 on pi, captures both output buses one
// edge later and accumulates error metrics one edge after that.
//   clk, rst     : clock, synchronous active-high reset
//   start        : sweep request, honoured only in IDLE or DONE
//   pi           : pattern driven to both partitions
//   po_exact     : exact partition output
//   po_approx    : approximate partition output
//   busy / done  : sweep in progress / metrics final and frozen
//   err_count, ham_sum, abs_err_sum, max_abs_err : accumulated metrics
module partition_exhaustive_checker
    import partition_sweep_pkg::*;
#(
    parameter int NUM_IN  = DEF_NUM_IN,
    parameter int NUM_OUT = DEF_NUM_OUT,
    localparam int PW     = pop_w(NUM_OUT),
    localparam int EW     = err_w(NUM_IN),
    localparam int HW     = ham_w(NUM_IN, NUM_OUT),
    localparam int AW     = abs_sum_w(NUM_IN, NUM_OUT)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic [NUM_IN-1:0]  pi,
    input  logic [NUM_OUT-1:0] po_exact,
    input  logic [NUM_OUT-1:0] po_approx,
    output logic               busy,
    output logic               done,
    output logic [EW-1:0]      err_count,
    output logic [HW-1:0]      ham_sum,
    output logic [AW-1:0]      abs_err_sum,
    output logic [NUM_OUT-1:0] max_abs_err
);

    sweep_state_e       state_q, state_d;
    logic [NUM_IN-1:0]  pi_q, pi_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [NUM_OUT-1:0] exact_p1_q, exact_p1_d;
    logic [NUM_OUT-1:0] approx_p1_q, approx_p1_d;
    logic               vld_p1_q, vld_p1_d;
    logic [EW-1:0]      err_q, err_d;
    logic [HW-1:0]      ham_q, ham_d;
    logic [AW-1:0]      abs_q, abs_d;
    logic [NUM_OUT-1:0] max_q, max_d;

    logic               mismatch_p1;
    logic [PW-1:0]      popcount_p1;
    logic [NUM_OUT-1:0] abs_err_p1;

    sweep_err_metric #(.NUM_OUT(NUM_OUT)) u_metric (
        .exact    (exact_p1_q),
        .approx   (approx_p1_q),
        .mismatch (mismatch_p1),
        .popcount (popcount_p1),
        .abs_err  (abs_err_p1)
    );

    always_comb begin
        state_d     = state_q;
        pi_d        = pi_q;
        exact_p1_d  = exact_p1_q;
        approx_p1_d = approx_p1_q;
        vld_p1_d    = 1'b0;
        err_d       = err_q;
        ham_d       = ham_q;
        abs_d       = abs_q;
        max_d       = max_q;

        // Stage 2: fold the capture taken on the previous edge into the metrics.
        if (vld_p1_q) begin
            err_d = err_q + EW'(mismatch_p1);
            ham_d = ham_q + HW'(popcount_p1);
            abs_d = abs_q + AW'(abs_err_p1);
            if (abs_err_p1 > max_q) begin
                max_d = abs_err_p1;
            end
        end

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = SWEEP;
                    pi_d    = '0;
                    err_d   = '0;
                    ham_d   = '0;
                    abs_d   = '0;
                    max_d   = '0;
                end
            end
            SWEEP: begin
                // Stage 1: capture both buses for the pattern currently on pi.
                exact_p1_d  = po_exact;
                approx_p1_d = po_approx;
                vld_p1_d    = 1'b1;
                if (pi_q == {NUM_IN{1'b1}}) begin
                    state_d = DRAIN;
                end else begin
                    pi_d = pi_q + NUM_IN'(1);
                end
            end
            DRAIN: begin
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == SWEEP) || (state_d == DRAIN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            pi_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            vld_p1_q <= 1'b0;
            err_q    <= '0;
            ham_q    <= '0;
            abs_q    <= '0;
            max_q    <= '0;
        end else begin
            state_q  <= state_d;
            pi_q     <= pi_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            vld_p1_q <= vld_p1_d;
            err_q    <= err_d;
            ham_q    <= ham_d;
            abs_q    <= abs_d;
            max_q    <= max_d;
        end
    end

    // Capture data carries no reset; vld_p1_q gates every use of it.
    always_ff @(posedge clk) begin
        exact_p1_q  <= exact_p1_d;
        approx_p1_q <= approx_p1_d;
    end

    assign pi          = pi_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err_count   = err_q;
    assign ham_sum     = ham_q;
    assign abs_err_sum = abs_q;
    assign max_abs_err = max_q;

endmodule

// File: tb/tb_partition_exhaustive_checker.sv
module tb_partition_exhaustive_checker;

    localparam int NI = 7;
    localparam int NO = 4;
    localparam int NPAT = 2 ** NI;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [NI-1:0] pi;
    logic [NO-1:0] po_exact;
    logic [NO-1:0] po_approx;
    logic          busy;
    logic          done;
    logic [7:0]    err_count;
    logic [9:0]    ham_sum;
    logic [10:0]   abs_err_sum;
    logic [3:0]    max_abs_err;

    int n_cmp = 0;
    int n_bad = 0;

    // Approximation under test: 0 identical, 1 lsb cleared, 2 inverted, 3 random xor mask
    int         mode = 0;
    logic [3:0] lut [NPAT];

    int m_err, m_ham, m_abs, m_max;

    partition_exhaustive_checker dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .pi          (pi),
        .po_exact    (po_exact),
        .po_approx   (po_approx),
        .busy        (busy),
        .done        (done),
        .err_count   (err_count),
        .ham_sum     (ham_sum),
        .abs_err_sum (abs_err_sum),
        .max_abs_err (max_abs_err)
    );

    always #5 clk = ~clk;

    // Exact partition: 3-bit + 4-bit adder, low 4 bits of the sum.
    function automatic int exact_of(input int p);
        return ((p & 7) + ((p >> 3) & 15)) & 15;
    endfunction

    function automatic int approx_of(input int p);
        int e;
        e = exact_of(p);
        case (mode)
            0:       return e;
            1:       return e & 14;
            2:       return 15 - e;
            default: return e ^ int'(lut[p]);
        endcase
    endfunction

    always_comb begin
        po_exact  = 4'(exact_of(int'(pi)));
        po_approx = 4'(approx_of(int'(pi)));
    end

    // Reference: metrics over the whole pattern space, straight from their definitions.
    task automatic compute_model();
        int e, a, d;
        m_err = 0; m_ham = 0; m_abs = 0; m_max = 0;
        for (int p = 0; p < NPAT; p++) begin
            e = exact_of(p);
            a = approx_of(p);
            d = (e > a) ? e - a : a - e;
            if (e != a) m_err++;
            m_ham += $countones(4'(e ^ a));
            m_abs += d;
            if (d > m_max) m_max = d;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!done && cyc < 400) begin
            step();
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0;
        step(); step();
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %0b expected 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %0b expected 0", done); end
        n_cmp++; if (pi !== 7'd0) begin n_bad++; $display("FAIL reset_pi got %0d expected 0", pi); end
        n_cmp++; if ({err_count, ham_sum, abs_err_sum, max_abs_err} !== 33'd0) begin
            n_bad++; $display("FAIL reset_metrics got %0d/%0d/%0d/%0d expected 0/0/0/0",
                              err_count, ham_sum, abs_err_sum, max_abs_err);
        end
        start = 1'b1;
        step();
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_beats_start got busy=%0b expected 0", busy); end
        start = 1'b0;
        rst = 1'b0;
        step();
        n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin
            n_bad++; $display("FAIL idle_after_reset got busy=%0b done=%0b expected 0/0", busy, done);
        end
    endtask

    task automatic test_sweep(input string name, input int md);
        int cyc;
        mode = md;
        compute_model();
        do_start();
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL %s_busy got %0b expected 1", name, busy); end
        wait_done(cyc);
        n_cmp++; if (cyc != 129) begin n_bad++; $display("FAIL %s_latency got %0d expected 129", name, cyc); end
        n_cmp++; if (int'(err_count) != m_err) begin n_bad++; $display("FAIL %s_err_count got %0d expected %0d", name, err_count, m_err); end
        n_cmp++; if (int'(ham_sum) != m_ham) begin n_bad++; $display("FAIL %s_ham_sum got %0d expected %0d", name, ham_sum, m_ham); end
        n_cmp++; if (int'(abs_err_sum) != m_abs) begin n_bad++; $display("FAIL %s_abs_err_sum got %0d expected %0d", name, abs_err_sum, m_abs); end
        n_cmp++; if (int'(max_abs_err) != m_max) begin n_bad++; $display("FAIL %s_max_abs_err got %0d expected %0d", name, max_abs_err, m_max); end
        step(); step();
        n_cmp++; if (done !== 1'b1 || busy !== 1'b0 || int'(err_count) != m_err || pi !== 7'd127) begin
            n_bad++; $display("FAIL %s_frozen got done=%0b busy=%0b err=%0d pi=%0d expected 1/0/%0d/127",
                              name, done, busy, err_count, pi, m_err);
        end
    endtask

    task automatic test_invert_pi_sequence();
        int exp_pi;
        mode = 2;
        compute_model();
        do_start();
        n_cmp++; if (pi !== 7'd0) begin n_bad++; $display("FAIL inv_pi_start got %0d expected 0", pi); end
        for (int c = 1; c <= 129; c++) begin
            step();
            exp_pi = (c > 127) ? 127 : c;
            n_cmp++; if (int'(pi) != exp_pi) begin n_bad++; $display("FAIL inv_pi_c%0d got %0d expected %0d", c, pi, exp_pi); end
            n_cmp++; if (done !== (c == 129)) begin n_bad++; $display("FAIL inv_done_c%0d got %0b expected %0b", c, done, c == 129); end
        end
        n_cmp++; if (int'(err_count) != m_err || int'(ham_sum) != m_ham || int'(abs_err_sum) != m_abs || int'(max_abs_err) != m_max) begin
            n_bad++; $display("FAIL inv_metrics got %0d/%0d/%0d/%0d expected %0d/%0d/%0d/%0d",
                              err_count, ham_sum, abs_err_sum, max_abs_err, m_err, m_ham, m_abs, m_max);
        end
    endtask

    task automatic test_rst_mid_sweep();
        int guard;
        mode = 1;
        do_start();
        guard = 0;
        while (pi !== 7'd50 && guard < 200) begin step(); guard++; end
        n_cmp++; if (pi !== 7'd50) begin n_bad++; $display("FAIL rst_mid_reach got pi=%0d expected 50", pi); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_cmp++; if (busy !== 1'b0 || done !== 1'b0 || pi !== 7'd0) begin
            n_bad++; $display("FAIL rst_mid_state got busy=%0b done=%0b pi=%0d expected 0/0/0", busy, done, pi);
        end
        n_cmp++; if ({err_count, ham_sum, abs_err_sum, max_abs_err} !== 33'd0) begin
            n_bad++; $display("FAIL rst_mid_metrics got %0d/%0d/%0d/%0d expected 0/0/0/0",
                              err_count, ham_sum, abs_err_sum, max_abs_err);
        end
        test_sweep("after_rst", 1);
    endtask

    task automatic test_start_ignored_and_restart();
        int cyc;
        mode = 1;
        compute_model();
        do_start();
        cyc = 0;
        while (!done && cyc < 400) begin
            start = (cyc == 10 || cyc == 128);
            step();
            cyc++;
        end
        start = 1'b0;
        n_cmp++; if (cyc != 129) begin n_bad++; $display("FAIL ignore_latency got %0d expected 129", cyc); end
        n_cmp++; if (int'(err_count) != m_err || int'(ham_sum) != m_ham || int'(abs_err_sum) != m_abs || int'(max_abs_err) != m_max) begin
            n_bad++; $display("FAIL ignore_metrics got %0d/%0d/%0d/%0d expected %0d/%0d/%0d/%0d",
                              err_count, ham_sum, abs_err_sum, max_abs_err, m_err, m_ham, m_abs, m_max);
        end
        do_start();
        n_cmp++; if ({err_count, ham_sum, abs_err_sum, max_abs_err} !== 33'd0) begin
            n_bad++; $display("FAIL restart_clear got %0d/%0d/%0d/%0d expected 0/0/0/0",
                              err_count, ham_sum, abs_err_sum, max_abs_err);
        end
        n_cmp++; if (busy !== 1'b1 || done !== 1'b0 || pi !== 7'd0) begin
            n_bad++; $display("FAIL restart_state got busy=%0b done=%0b pi=%0d expected 1/0/0", busy, done, pi);
        end
        wait_done(cyc);
        n_cmp++; if (cyc != 129) begin n_bad++; $display("FAIL restart_latency got %0d expected 129", cyc); end
        n_cmp++; if (int'(err_count) != m_err || int'(ham_sum) != m_ham || int'(abs_err_sum) != m_abs || int'(max_abs_err) != m_max) begin
            n_bad++; $display("FAIL restart_metrics got %0d/%0d/%0d/%0d expected %0d/%0d/%0d/%0d",
                              err_count, ham_sum, abs_err_sum, max_abs_err, m_err, m_ham, m_abs, m_max);
        end
    endtask

    task automatic test_random(input int rounds);
        for (int r = 0; r < rounds; r++) begin
            for (int p = 0; p < NPAT; p++) begin
                lut[p] = 4'($urandom_range(0, 15));
            end
            test_sweep("random", 3);
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        for (int p = 0; p < NPAT; p++) lut[p] = 4'd0;
        test_reset();
        test_sweep("identical", 0);
        test_sweep("mask_lsb", 1);
        test_invert_pi_sequence();
        test_rst_mid_sweep();
        test_start_ignored_and_restart();
        test_random(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
